// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state codes, opcodes, opcode classes and datapath select codes for multicycle_ctrl
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic PC_PLUS4 = 1'b0;
    localparam logic PC_IMM   = 1'b1;

    typedef struct packed {
        logic r;
        logic ialu;
        logic load;
        logic store;
        logic branch;
        logic jal;
    } op_class_t;

    function automatic logic uses_imm(input op_class_t c);
        return c.ialu | c.load | c.store;
    endfunction

endpackage

// File: rtl/op_decode.sv
// op_decode: one-hot opcode classification; anything outside the six supported classes is illegal
module op_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       illegal
);

    always_comb begin
        cls.r      = opcode == OP_R;
        cls.ialu   = opcode == OP_IALU;
        cls.load   = opcode == OP_LOAD;
        cls.store  = opcode == OP_STORE;
        cls.branch = opcode == OP_BRANCH;
        cls.jal    = opcode == OP_JAL;
        illegal    = ~|cls;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM with sticky illegal trap and retire counter
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        reg_we,
    output logic        alu_src_imm,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    state_t    st;
    op_class_t cls_q;
    op_class_t dec_cls;
    logic      dec_ill;
    logic      retire;

    op_decode u_dec (
        .opcode  (opcode),
        .cls     (dec_cls),
        .illegal (dec_ill)
    );

    assign state = st;

    assign retire = (st == S_EXEC && cls_q.branch)
                  | (st == S_MEM && cls_q.store && mem_ready)
                  | (st == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_FETCH;
            cls_q   <= '0;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            if (retire)
                instret <= instret + 32'd1;
            case (st)
                S_FETCH:  if (mem_ready) st <= S_DECODE;
                S_DECODE: begin
                    cls_q <= dec_cls;
                    st    <= dec_ill ? S_TRAP : S_EXEC;
                    if (dec_ill)
                        illegal <= 1'b1;
                end
                S_EXEC:   st <= (cls_q.r | cls_q.ialu | cls_q.jal) ? S_WB
                              : (cls_q.load | cls_q.store) ? S_MEM : S_FETCH;
                S_MEM:    if (mem_ready) st <= cls_q.store ? S_FETCH : S_WB;
                S_WB:     st <= S_FETCH;
                S_TRAP:   st <= S_TRAP;
                default:  st <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst_n so an access in flight is dropped the instant reset asserts
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_PLUS4;
        reg_we      = 1'b0;
        alu_src_imm = 1'b0;
        wb_sel      = WB_ALU;
        if (rst_n) begin
            case (st)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                S_EXEC: begin
                    alu_src_imm = uses_imm(cls_q);
                    pc_we       = cls_q.branch;
                    pc_src      = cls_q.branch ? branch_cond : PC_PLUS4;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = cls_q.store;
                    pc_we   = cls_q.store & mem_ready;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    pc_src = cls_q.jal ? PC_IMM : PC_PLUS4;
                    wb_sel = cls_q.jal ? WB_PC4 : cls_q.load ? WB_MEM : WB_ALU;
                end
                default: ;
            endcase
        end
    end

endmodule
